// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA prefetch reads win the single RAM port, capture writes drain from a FIFO.
// Optional statistics counters are enabled with `define FB_ARB_STATS_EN.
`timescale 1ns/1ps
module fb_port_arbiter #(
    parameter int DW         = 12,
    parameter int AW         = 15,
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posX,
    input  logic [9:0]    posY,
    output logic [DW-1:0] pixel_to_vga,
    input  logic          cap_valid,
    output logic          cap_ready,
    input  logic [AW-1:0] cap_addr,
    input  logic [DW-1:0] cap_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   stall_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [10:0]   nx;
    logic [9:0]    ny;
    logic          en_q;
    logic          read_slot;
    logic [AW-1:0] rd_addr;
    logic          in_range;
    logic          push_ok;
    logic          pop;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          cap_ready_q;
    logic          rd_pend_q;
    logic [DW-1:0] pixel_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];

    // Lookahead two pixels so the read result lands exactly when the driver reaches that pixel.
    // NOTE: blocking assignments in combinational logic; each statement sees the previous one's result.
    always_comb begin
        nx = {1'b0, posX} + 11'd2;
        ny = posY;
        if (nx >= 11'd800) begin
            nx = nx - 11'd800;
            ny = ny + 10'd1;
        end
        if (ny >= 10'd525) ny = 10'd0;
    end

    assign read_slot = en_q && (nx < 11'd640) && (ny < 10'd480) && (nx[1:0] == 2'b00);
    assign rd_addr   = AW'(ny[9:2]) * AW'(IMG_W) + AW'(nx[10:2]);
    assign in_range  = 32'(cap_addr) < 32'(IMG_W * IMG_H);
    assign push_ok   = cap_valid && cap_ready_q && in_range;
    assign pop       = !read_slot && (count_q != '0);
    assign count_d   = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        if (read_slot) begin
            mem_addr = rd_addr;
        end else if (pop) begin
            mem_addr  = fifo_addr_q[rd_ptr_q];
            mem_wdata = fifo_data_q[rd_ptr_q];
            mem_we    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q        <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cap_ready_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            pixel_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            en_q        <= 1'b1;
            count_q     <= count_d;
            cap_ready_q <= count_d < (PW+1)'(FIFO_DEPTH);
            rd_pend_q   <= read_slot;
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (rd_pend_q) pixel_q <= mem_rdata;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr_q[wr_ptr_q] <= cap_addr;
            fifo_data_q[wr_ptr_q] <= cap_data;
        end
    end

    assign pixel_to_vga = pixel_q;
    assign cap_ready    = cap_ready_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] drop_q, stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q  <= '0;
            stall_q <= '0;
        end else begin
            if (cap_valid && cap_ready_q && !in_range && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
            if (cap_valid && !cap_ready_q && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign drop_cnt  = drop_q;
    assign stall_cnt = stall_q;
`else
    assign drop_cnt  = 16'd0;
    assign stall_cnt = 16'd0;
`endif

endmodule
